// File: rtl/mux8x1_scan_sequencer.sv
// Drives a word onto an 8:1 mux, walks the select 0..7, and reassembles the
// sampled mux output into data_out, flagging any loopback mismatch.
module mux8x1_scan_sequencer #(
  parameter int DWELL = 1,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       mux_y,
  output logic [7:0] mux_i,
  output logic [2:0] mux_sel,
  output logic       busy,
  output logic       done,
  output logic [7:0] data_out,
  output logic       error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       mux_i_q, mux_i_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             error_q, error_d;
  logic [6:0]       cap_q, cap_d;
  logic [7:0]       word_s;

  // Next-state and output computation for the scan sequencer
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    sel_d      = sel_q;
    mux_i_d    = mux_i_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    error_d    = error_q;
    cap_d      = cap_q;
    // Bit 7 is never stored: the final sample goes straight into the result.
    word_s     = {mux_y, cap_q};
    case (state_q)
      IDLE: begin
        if (start) begin
          mux_i_d = data_in;
          sel_d   = 3'd0;
          dwell_d = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (dwell_q < DWELL_LAST) begin
          dwell_d = dwell_q + CNT_W'(1);
        end else begin
          dwell_d = '0;
          for (int k = 0; k < 7; k++) begin
            if (sel_q == 3'(k)) begin
              cap_d[k] = mux_y;
            end else begin
              cap_d[k] = cap_q[k];
            end
          end
          if (sel_q != 3'd7) begin
            sel_d = sel_q + 3'd1;
          end else begin
            data_out_d = word_s;
            error_d    = (word_s != mux_i_q);
            done_d     = 1'b1;
            busy_d     = 1'b0;
            sel_d      = 3'd0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dwell_q    <= '0;
      sel_q      <= 3'd0;
      mux_i_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= 8'd0;
      error_q    <= 1'b0;
      cap_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      sel_q      <= sel_d;
      mux_i_q    <= mux_i_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
      error_q    <= error_d;
      cap_q      <= cap_d;
    end
  end

  assign mux_i    = mux_i_q;
  assign mux_sel  = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;
  assign error    = error_q;

endmodule

// File: tb/tb_mux8x1_scan_sequencer.sv
// Scoreboard bench: two sequencers (DWELL=1 and DWELL=3) each looped back
// through a behavioural 8:1 mux, with an optional forced mux output.
module tb_mux8x1_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_a   [2];
  logic [7:0] din_a     [2];
  logic       y_a       [2];
  logic [7:0] mi_a      [2];
  logic [2:0] sel_a     [2];
  logic       busy_a    [2];
  logic       done_a    [2];
  logic [7:0] dout_a    [2];
  logic       err_a     [2];
  logic       force_en  [2];
  logic       force_val [2];

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] e0, e1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign y_a[0] = force_en[0] ? force_val[0] : mi_a[0][sel_a[0]];
  assign y_a[1] = force_en[1] ? force_val[1] : mi_a[1][sel_a[1]];

  mux8x1_scan_sequencer #(.DWELL(1), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .data_in(din_a[0]),
    .mux_y(y_a[0]), .mux_i(mi_a[0]), .mux_sel(sel_a[0]), .busy(busy_a[0]),
    .done(done_a[0]), .data_out(dout_a[0]), .error(err_a[0])
  );

  mux8x1_scan_sequencer #(.DWELL(3), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .data_in(din_a[1]),
    .mux_y(y_a[1]), .mux_i(mi_a[1]), .mux_sel(sel_a[1]), .busy(busy_a[1]),
    .done(done_a[1]), .data_out(dout_a[1]), .error(err_a[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a sequencer reports done
  always @(negedge clk) begin
    if (done_a[0]) begin
      if (q0.size() == 0) begin
        chk("unexpected_done0", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("data_out0", dout_a[0], e0[8:1]);
        chk("error0", err_a[0], e0[0]);
      end
    end
  end

  always @(negedge clk) begin
    if (done_a[1]) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("data_out1", dout_a[1], e1[8:1]);
        chk("error1", err_a[1], e1[0]);
      end
    end
  end

  // Issue one scan from a negedge and return at the negedge where done is seen.
  task automatic run(input int idx, input int d, input logic [7:0] v,
                     input logic [8:0] exp, input bit intrude);
    bit seen;
    int lat;
    seen = 1'b0;
    lat = 0;
    start_a[idx] = 1'b1;
    din_a[idx] = v;
    if (idx == 0) q0.push_back(exp);
    else q1.push_back(exp);
    for (int i = 1; i <= 8 * d + 10 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) start_a[idx] = 1'b0;
      if (intrude && i == 3) begin
        start_a[idx] = 1'b1;
        din_a[idx] = 8'hF0;
      end
      if (intrude && i == 4) start_a[idx] = 1'b0;
      if (intrude && i == 5) chk("mux_i_hold_busy", mi_a[idx], v);
      if (done_a[idx]) begin
        seen = 1'b1;
        lat = i;
      end else if (i <= 8 * d) begin
        chk("sel_step", sel_a[idx], (i - 1) / d);
        chk("busy_scan", busy_a[idx], 1);
      end
    end
    chk("done_timeout", seen, 1);
    if (seen) begin
      chk("latency", lat, 8 * d + 1);
      chk("busy_at_done", busy_a[idx], 0);
      chk("sel_at_done", sel_a[idx], 0);
      chk("mux_i_after", mi_a[idx], v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_a[k] = 1'b0;
      din_a[k] = 8'h00;
      force_en[k] = 1'b0;
      force_val[k] = 1'b0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mux_i", mi_a[k], 0);
      chk("rst_sel", sel_a[k], 0);
      chk("rst_busy", busy_a[k], 0);
      chk("rst_done", done_a[k], 0);
      chk("rst_data_out", dout_a[k], 0);
      chk("rst_error", err_a[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 1, 8'hA5, {8'hA5, 1'b0}, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done_a[0], 0);

    force_en[0] = 1'b1;
    force_val[0] = 1'b0;
    run(0, 1, 8'hA5, {8'h00, 1'b1}, 1'b0);
    force_val[0] = 1'b1;
    run(0, 1, 8'hFF, {8'hFF, 1'b0}, 1'b0);
    run(0, 1, 8'h00, {8'hFF, 1'b1}, 1'b0);
    force_en[0] = 1'b0;
    @(negedge clk);

    run(1, 3, 8'h3C, {8'h3C, 1'b0}, 1'b0);
    @(negedge clk);

    run(0, 1, 8'h0F, {8'h0F, 1'b0}, 1'b1);
    run(0, 1, 8'h81, {8'h81, 1'b0}, 1'b0);
    @(negedge clk);

    start_a[0] = 1'b1;
    din_a[0] = 8'h33;
    @(negedge clk);
    start_a[0] = 1'b0;
    for (int i = 0; i < 20 && sel_a[0] != 3'd4; i++) @(negedge clk);
    chk("reached_sel4", sel_a[0], 4);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mux_i", mi_a[0], 0);
    chk("abort_sel", sel_a[0], 0);
    chk("abort_busy", busy_a[0], 0);
    chk("abort_done", done_a[0], 0);
    chk("abort_data_out", dout_a[0], 0);
    chk("abort_error", err_a[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done_a[0], 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_abort_no_done", done_a[0], 0);
    end
    run(0, 1, 8'h5A, {8'h5A, 1'b0}, 1'b0);

    for (int v = 0; v < 256; v++) begin
      run(0, 1, 8'(v), {8'(v), 1'b0}, 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
